femto_bus_fabric: RTL and testbench

// Parametrised address decoder / read-data mux / busy arbiter between FemtoRV32 and N memory-mapped

---
 rtl/femto_bus_fabric_if.sv | 32 +++
 rtl/femto_bus_fabric.sv | 150 +++++++++++++++
 tb/tb_femto_bus_fabric.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/femto_bus_fabric_if.sv
// Signal bundle between FemtoRV32, the bus fabric and its memory-mapped slaves.
// cpu_wdata bypasses the fabric and reaches every slave directly, so only the master modport carries it.
interface femto_bus_fabric_if #(
  parameter int NSLAVES = 8
);
  logic [31:0]           cpu_addr;
  logic [31:0]           cpu_wdata;
  logic [3:0]            cpu_wmask;
  logic                  cpu_rstrb;
  logic [31:0]           cpu_rdata;
  logic                  cpu_rbusy;
  logic                  cpu_wbusy;
  logic [NSLAVES-1:0]    s_rd;
  logic [NSLAVES-1:0]    s_wr;
  logic [32*NSLAVES-1:0] s_rdata;
  logic [NSLAVES-1:0]    s_rbusy;
  logic [NSLAVES-1:0]    s_wbusy;
  logic                  err_clr;
  logic                  err_valid;
  logic [1:0]            err_code;
  logic [31:0]           err_addr;

  modport slave (
    input  cpu_addr, cpu_wmask, cpu_rstrb, s_rdata, s_rbusy, s_wbusy, err_clr,
    output cpu_rdata, cpu_rbusy, cpu_wbusy, s_rd, s_wr, err_valid, err_code, err_addr
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_wmask, cpu_rstrb, s_rdata, s_rbusy, s_wbusy, err_clr,
    input  cpu_rdata, cpu_rbusy, cpu_wbusy, s_rd, s_wr, err_valid, err_code, err_addr
  );
endinterface

// File: rtl/femto_bus_fabric.sv
// Table-driven address decoder, read-data mux and busy arbiter between FemtoRV32 and N slaves,
// with a per-access busy timeout and sticky capture of the first unmapped/timeout error.
module femto_bus_fabric #(
  parameter int                    NSLAVES       = 8,
  parameter logic [16*NSLAVES-1:0] SLAVE_PAGES   = {16'h0047, 16'h0046, 16'h0045, 16'h0044,
                                                    16'h0043, 16'h0042, 16'h0041, 16'h0040},
  parameter int                    DEFAULT_SLAVE = 0,
  parameter int                    TIMEOUT       = 255,
  parameter logic [31:0]           ERR_RDATA     = 32'hDEAD_BEEF
) (
  input  logic             clk,
  input  logic             resetn,
  femto_bus_fabric_if.slave bus
);
  localparam int          SELW        = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
  localparam bit          DEF_MAPPED  = (DEFAULT_SLAVE >= 0) && (DEFAULT_SLAVE < NSLAVES);
  localparam int          DEF_IDX     = DEF_MAPPED ? DEFAULT_SLAVE : 0;
  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] WR_WAIT = 2'd2;
  localparam logic [1:0] ERR_RSP = 2'd3;

  localparam logic [1:0] ERR_UNMAPPED = 2'b01;
  localparam logic [1:0] ERR_RD_TO    = 2'b10;
  localparam logic [1:0] ERR_WR_TO    = 2'b11;

  logic [1:0]         state_q, state_d;
  logic [SELW-1:0]    sel_q, sel_d;
  logic               mapped_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [31:0]        addr_q;
  logic               errRead_q;
  logic               errValid_q, errValid_d;
  logic [1:0]         errCode_q, errCode_d;
  logic [31:0]        errAddr_q, errAddr_d;

  logic               wrReq, rdReq, accept;
  logic               waiting, slaveBusy, timeoutHit;
  logic               errEvent;
  logic [1:0]         errCode;
  logic [31:0]        errAddr;
  logic [NSLAVES-1:0] selOneHot;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    sel_d    = SELW'(DEF_IDX);
    mapped_d = DEF_MAPPED;
    for (int i = NSLAVES - 1; i >= 0; i--) begin
      if (bus.cpu_addr[31:16] == SLAVE_PAGES[16*i +: 16]) begin
        sel_d    = SELW'(i);
        mapped_d = 1'b1;
      end
    end
  end

  assign wrReq     = |bus.cpu_wmask;
  assign rdReq     = bus.cpu_rstrb & ~wrReq;
  assign accept    = (state_q == IDLE) & (wrReq | rdReq);
  assign selOneHot = NSLAVES'(1) << sel_d;
  assign bus.s_wr  = (accept & mapped_d & wrReq) ? selOneHot : '0;
  assign bus.s_rd  = (accept & mapped_d & rdReq) ? selOneHot : '0;

  assign waiting       = (state_q == RD_WAIT) | (state_q == WR_WAIT);
  assign slaveBusy     = (state_q == RD_WAIT) ? bus.s_rbusy[sel_q] : bus.s_wbusy[sel_q];
  assign timeoutHit    = waiting & slaveBusy & (cnt_q == TIMEOUT_CNT);
  assign bus.cpu_rbusy = (state_q == RD_WAIT) & slaveBusy & ~timeoutHit;
  assign bus.cpu_wbusy = (state_q == WR_WAIT) & slaveBusy & ~timeoutHit;

  // sel_q, not the live address, picks the data so it stays bound to the accessed slave.
  assign bus.cpu_rdata = (((state_q == ERR_RSP) & errRead_q) | ((state_q == RD_WAIT) & timeoutHit))
                         ? ERR_RDATA : bus.s_rdata[32*sel_q +: 32];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    errEvent = 1'b0;
    errCode  = ERR_UNMAPPED;
    errAddr  = bus.cpu_addr;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d = '0;
          if (!mapped_d) begin
            state_d  = ERR_RSP;
            errEvent = 1'b1;
          end else begin
            state_d = wrReq ? WR_WAIT : RD_WAIT;
          end
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (timeoutHit) begin
          state_d  = IDLE;
          errEvent = 1'b1;
          errCode  = (state_q == RD_WAIT) ? ERR_RD_TO : ERR_WR_TO;
          errAddr  = addr_q;
        end else if (slaveBusy) begin
          cnt_d = cnt_q + 16'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A new error wins over a coincident clear; otherwise the first error is held.
  always_comb begin
    errValid_d = errValid_q;
    errCode_d  = errCode_q;
    errAddr_d  = errAddr_q;
    if (errEvent && (!errValid_q || bus.err_clr)) begin
      errValid_d = 1'b1;
      errCode_d  = errCode;
      errAddr_d  = errAddr;
    end else if (bus.err_clr) begin
      errValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      sel_q      <= SELW'(DEF_IDX);
      cnt_q      <= '0;
      addr_q     <= '0;
      errRead_q  <= 1'b0;
      errValid_q <= 1'b0;
      errCode_q  <= '0;
      errAddr_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      errValid_q <= errValid_d;
      errCode_q  <= errCode_d;
      errAddr_q  <= errAddr_d;
      if (accept) begin
        sel_q     <= sel_d;
        addr_q    <= bus.cpu_addr;
        errRead_q <= rdReq;
      end
    end
  end

  assign bus.err_valid = errValid_q;
  assign bus.err_code  = errCode_q;
  assign bus.err_addr  = errAddr_q;
endmodule

// File: tb/tb_femto_bus_fabric.sv
// Directed bench: dutA maps unmapped pages to slave 0 with a long timeout,
// dutB treats them as errors and times out after 10 busy cycles; both see the same stimulus.
module tb_femto_bus_fabric;
  localparam int NS = 8;
  // Slave 0 flash, 1 UART, 2 SPI RAM, 3..6 misc, 7 overlaps UART's page.
  localparam logic [16*NS-1:0] PAGES = {16'h0040, 16'h0044, 16'h0043, 16'h0042,
                                        16'h0041, 16'h0020, 16'h0040, 16'h0000};

  logic           clk = 1'b0;
  logic           resetn;
  logic [31:0]    addr;
  logic [3:0]     wmask;
  logic           rstrb;
  logic           errClr;
  logic [32*NS-1:0] sData;
  logic [NS-1:0]  sRbusy;
  logic [NS-1:0]  sWbusy;
  int             checks = 0;
  int             errors = 0;
  int             hiA, hiB;

  femto_bus_fabric_if #(.NSLAVES(NS)) busA ();
  femto_bus_fabric_if #(.NSLAVES(NS)) busB ();

  assign busA.cpu_addr  = addr;    assign busB.cpu_addr  = addr;
  assign busA.cpu_wdata = 32'h0;   assign busB.cpu_wdata = 32'h0;
  assign busA.cpu_wmask = wmask;   assign busB.cpu_wmask = wmask;
  assign busA.cpu_rstrb = rstrb;   assign busB.cpu_rstrb = rstrb;
  assign busA.s_rdata   = sData;   assign busB.s_rdata   = sData;
  assign busA.s_rbusy   = sRbusy;  assign busB.s_rbusy   = sRbusy;
  assign busA.s_wbusy   = sWbusy;  assign busB.s_wbusy   = sWbusy;
  assign busA.err_clr   = errClr;  assign busB.err_clr   = errClr;

  femto_bus_fabric #(.NSLAVES(NS), .SLAVE_PAGES(PAGES), .DEFAULT_SLAVE(0),
                     .TIMEOUT(255), .ERR_RDATA(32'hDEAD_BEEF))
    dutA (.clk(clk), .resetn(resetn), .bus(busA));

  femto_bus_fabric #(.NSLAVES(NS), .SLAVE_PAGES(PAGES), .DEFAULT_SLAVE(NS),
                     .TIMEOUT(10), .ERR_RDATA(32'hDEAD_BEEF))
    dutB (.clk(clk), .resetn(resetn), .bus(busB));

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive a CPU request on the falling edge and let combinational outputs settle.
  task automatic applyStimulus(input logic [31:0] a, input logic [3:0] m, input logic r);
    @(negedge clk);
    addr  = a;
    wmask = m;
    rstrb = r;
    #1;
  endtask

  initial begin
    resetn = 1'b0; addr = '0; wmask = '0; rstrb = 1'b0; errClr = 1'b0;
    sRbusy = '0; sWbusy = '0;
    for (int i = 0; i < NS; i++) sData[32*i +: 32] = 32'hA000_0000 + 32'(i);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rstRbusy",    32'(busA.cpu_rbusy), 32'h0);
    checkOutput("rstWbusy",    32'(busA.cpu_wbusy), 32'h0);
    checkOutput("rstErrValid", 32'(busB.err_valid), 32'h0);
    checkOutput("rstErrCode",  32'(busB.err_code),  32'h0);
    checkOutput("rstErrAddr",  busB.err_addr,       32'h0);
    checkOutput("rstRdata",    busA.cpu_rdata,      32'hA000_0000);
    resetn = 1'b1;

    // UART read, zero wait states; slave 7 shares the page but slave 1 wins.
    applyStimulus(32'h0040_0004, 4'b0000, 1'b1);
    checkOutput("t1SrdOneHot", 32'(busA.s_rd), 32'h02);
    applyStimulus(32'h0040_0004, 4'b0000, 1'b0);
    checkOutput("t1Rdata",  busA.cpu_rdata,      32'hA000_0001);
    checkOutput("t1Rbusy",  32'(busA.cpu_rbusy), 32'h0);
    checkOutput("t1SrdOff", 32'(busA.s_rd),      32'h0);

    // Flash read held busy 20 cycles: dutA follows it, dutB aborts at 10.
    applyStimulus(32'h0000_0100, 4'b0000, 1'b1);
    checkOutput("t2SrdA", 32'(busA.s_rd), 32'h01);
    checkOutput("t2SrdB", 32'(busB.s_rd), 32'h01);
    @(negedge clk);
    rstrb = 1'b0;
    sRbusy = 8'h01;
    hiA = 0; hiB = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (busA.cpu_rbusy) hiA++;
      if (busB.cpu_rbusy) hiB++;
      if (i == 10) checkOutput("t5TimeoutRdata", busB.cpu_rdata, 32'hDEAD_BEEF);
      @(negedge clk);
    end
    sRbusy = '0;
    #1;
    checkOutput("t2BusyCycles", 32'(hiA), 32'd20);
    checkOutput("t5BusyCycles", 32'(hiB), 32'd10);
    checkOutput("t2RbusyDrop",  32'(busA.cpu_rbusy), 32'h0);
    checkOutput("t2RdataDrop",  busA.cpu_rdata, 32'hA000_0000);
    @(negedge clk);
    #1;
    checkOutput("t2NoErr",     32'(busA.err_valid), 32'h0);
    checkOutput("t5ErrValid",  32'(busB.err_valid), 32'h1);
    checkOutput("t5ErrCode",   32'(busB.err_code),  32'h2);
    checkOutput("t5ErrAddr",   busB.err_addr,       32'h0000_0100);

    // Unmapped read while dutB still holds the timeout error: first error kept.
    applyStimulus(32'h1234_0000, 4'b0000, 1'b1);
    checkOutput("t5SrdB",     32'(busB.s_rd), 32'h0);
    checkOutput("t4DefaultA", 32'(busA.s_rd), 32'h01);
    applyStimulus(32'h1234_0000, 4'b0000, 1'b0);
    checkOutput("t5ErrRdataB", busB.cpu_rdata, 32'hDEAD_BEEF);
    checkOutput("t4RdataA",    busA.cpu_rdata, 32'hA000_0000);
    checkOutput("t5KeepCode",  32'(busB.err_code), 32'h2);
    checkOutput("t5KeepAddr",  busB.err_addr,      32'h0000_0100);

    @(negedge clk);
    errClr = 1'b1;
    @(negedge clk);
    errClr = 1'b0;
    #1;
    checkOutput("clrValid", 32'(busB.err_valid), 32'h0);

    // Unmapped read on a clean error register.
    applyStimulus(32'h1234_0008, 4'b0000, 1'b1);
    checkOutput("t4NoSrd", 32'(busB.s_rd), 32'h0);
    applyStimulus(32'h1234_0008, 4'b0000, 1'b0);
    checkOutput("t4Rdata",    busB.cpu_rdata,      32'hDEAD_BEEF);
    checkOutput("t4Rbusy",    32'(busB.cpu_rbusy), 32'h0);
    checkOutput("t4ErrValid", 32'(busB.err_valid), 32'h1);
    checkOutput("t4ErrCode",  32'(busB.err_code),  32'h1);
    checkOutput("t4ErrAddr",  busB.err_addr,       32'h1234_0008);

    // Clear and a new error in the same cycle: the new error is captured.
    @(negedge clk);
    addr = 32'h5678_0000; rstrb = 1'b1; errClr = 1'b1;
    @(negedge clk);
    rstrb = 1'b0; errClr = 1'b0;
    #1;
    checkOutput("t6ClrNewValid", 32'(busB.err_valid), 32'h1);
    checkOutput("t6ClrNewAddr",  busB.err_addr,       32'h5678_0000);
    @(negedge clk);
    errClr = 1'b1;
    @(negedge clk);
    errClr = 1'b0;

    // UART write with rstrb also high: write only, single-cycle strobe.
    applyStimulus(32'h0040_0000, 4'b0001, 1'b1);
    checkOutput("t3SwrOneHot", 32'(busA.s_wr), 32'h02);
    checkOutput("t3SrdSupp",   32'(busA.s_rd), 32'h0);
    applyStimulus(32'h0040_0000, 4'b0000, 1'b0);
    checkOutput("t3SwrPulse", 32'(busA.s_wr),      32'h0);
    checkOutput("t3Wbusy",    32'(busA.cpu_wbusy), 32'h0);
    applyStimulus(32'h0042_0000, 4'b0000, 1'b1);
    checkOutput("t3BackIdle", 32'(busA.s_rd), 32'h10);
    applyStimulus(32'h0042_0000, 4'b0000, 1'b0);

    // SPI RAM write held busy 12 cycles: dutB logs a write timeout.
    applyStimulus(32'h0020_0000, 4'b1100, 1'b0);
    checkOutput("wtSwr", 32'(busA.s_wr), 32'h04);
    @(negedge clk);
    wmask = '0;
    sWbusy = 8'h04;
    hiA = 0; hiB = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (busA.cpu_wbusy) hiA++;
      if (busB.cpu_wbusy) hiB++;
      @(negedge clk);
    end
    sWbusy = '0;
    #1;
    checkOutput("wtBusyA", 32'(hiA), 32'd12);
    checkOutput("wtBusyB", 32'(hiB), 32'd10);
    @(negedge clk);
    #1;
    checkOutput("wtErrCode", 32'(busB.err_code), 32'h3);
    checkOutput("wtErrAddr", busB.err_addr,      32'h0020_0000);

    // Reset in the middle of a busy read aborts it without logging.
    applyStimulus(32'h0041_0000, 4'b0000, 1'b1);
    checkOutput("t6Srd", 32'(busA.s_rd), 32'h08);
    @(negedge clk);
    rstrb = 1'b0;
    sRbusy = 8'h08;
    #1;
    checkOutput("t6BusyBefore", 32'(busA.cpu_rbusy), 32'h1);
    resetn = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("t6RbusyAfter", 32'(busA.cpu_rbusy), 32'h0);
    checkOutput("t6ErrA",       32'(busA.err_valid), 32'h0);
    checkOutput("t6ErrB",       32'(busB.err_valid), 32'h0);
    resetn = 1'b1;
    sRbusy = '0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
